// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three per-producer result FIFOs drained round-robin
// onto one registered broadcast bus, with a rollback flush of all queued results.

module cdb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_empty,
  output logic         o_full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Full is judged on the registered count, so a pop in the same cycle never frees room.
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_head];

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst && !i_flush) r_mem[r_tail] <= i_data;
  end
endmodule

module cdb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rollback_in,
  input  logic              alu_valid_in,
  input  logic [TAG_W-1:0]  alu_tag_in,
  input  logic [WORD_W-1:0] alu_data_in,
  input  logic [WORD_W-1:0] alu_new_pc_in,
  output logic              alu_full_out,
  input  logic              lsb_valid_in,
  input  logic [TAG_W-1:0]  lsb_tag_in,
  input  logic [WORD_W-1:0] lsb_data_in,
  output logic              lsb_full_out,
  input  logic              rob_valid_in,
  input  logic [TAG_W-1:0]  rob_tag_in,
  input  logic [WORD_W-1:0] rob_data_in,
  output logic              rob_full_out,
  output logic              cdb_valid_out,
  output logic [TAG_W-1:0]  cdb_tag_out,
  output logic [WORD_W-1:0] cdb_data_out,
  output logic [WORD_W-1:0] cdb_new_pc_out,
  output logic [1:0]        cdb_src_out
);
  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LSB = 2'd1,
    SRC_ROB = 2'd2
  } src_e;

  localparam int ALU_W = TAG_W + 2 * WORD_W;
  localparam int RES_W = TAG_W + WORD_W;

  logic [ALU_W-1:0]  w_aluHead;
  logic [RES_W-1:0]  w_lsbHead;
  logic [RES_W-1:0]  w_robHead;
  logic              w_aluEmpty, w_lsbEmpty, w_robEmpty;
  logic              w_aluPush, w_lsbPush, w_robPush;
  logic              w_aluPop, w_lsbPop, w_robPop;
  logic              w_grantValid;
  src_e              w_grant;
  logic [TAG_W-1:0]  w_selTag;
  logic [WORD_W-1:0] w_selData;
  logic [WORD_W-1:0] w_selPc;

  src_e              r_lastGrant;
  logic              r_cdbValid;
  logic [TAG_W-1:0]  r_cdbTag;
  logic [WORD_W-1:0] r_cdbData;
  logic [WORD_W-1:0] r_cdbNewPc;
  src_e              r_cdbSrc;

  // Tag 0 is the null tag and never enters a queue.
  assign w_aluPush = alu_valid_in && (alu_tag_in != '0);
  assign w_lsbPush = lsb_valid_in && (lsb_tag_in != '0);
  assign w_robPush = rob_valid_in && (rob_tag_in != '0);

  assign w_aluPop = w_grantValid && (w_grant == SRC_ALU) && !rollback_in;
  assign w_lsbPop = w_grantValid && (w_grant == SRC_LSB) && !rollback_in;
  assign w_robPop = w_grantValid && (w_grant == SRC_ROB) && !rollback_in;

  cdb_fifo #(.DEPTH(DEPTH), .W(ALU_W)) u_aluFifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (rollback_in),
    .i_push  (w_aluPush),
    .i_data  ({alu_tag_in, alu_data_in, alu_new_pc_in}),
    .i_pop   (w_aluPop),
    .o_head  (w_aluHead),
    .o_empty (w_aluEmpty),
    .o_full  (alu_full_out)
  );

  cdb_fifo #(.DEPTH(DEPTH), .W(RES_W)) u_lsbFifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (rollback_in),
    .i_push  (w_lsbPush),
    .i_data  ({lsb_tag_in, lsb_data_in}),
    .i_pop   (w_lsbPop),
    .o_head  (w_lsbHead),
    .o_empty (w_lsbEmpty),
    .o_full  (lsb_full_out)
  );

  cdb_fifo #(.DEPTH(DEPTH), .W(RES_W)) u_robFifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (rollback_in),
    .i_push  (w_robPush),
    .i_data  ({rob_tag_in, rob_data_in}),
    .i_pop   (w_robPop),
    .o_head  (w_robHead),
    .o_empty (w_robEmpty),
    .o_full  (rob_full_out)
  );

  // Round-robin: the search starts at the source after the last winner.
  always_comb begin
    w_grantValid = !w_aluEmpty || !w_lsbEmpty || !w_robEmpty;
    w_grant      = SRC_ALU;
    case (r_lastGrant)
      SRC_ALU: begin
        if (!w_lsbEmpty)      w_grant = SRC_LSB;
        else if (!w_robEmpty) w_grant = SRC_ROB;
        else                  w_grant = SRC_ALU;
      end
      SRC_LSB: begin
        if (!w_robEmpty)      w_grant = SRC_ROB;
        else if (!w_aluEmpty) w_grant = SRC_ALU;
        else                  w_grant = SRC_LSB;
      end
      default: begin
        if (!w_aluEmpty)      w_grant = SRC_ALU;
        else if (!w_lsbEmpty) w_grant = SRC_LSB;
        else                  w_grant = SRC_ROB;
      end
    endcase
  end

  always_comb begin
    w_selTag  = w_aluHead[ALU_W-1 -: TAG_W];
    w_selData = w_aluHead[2*WORD_W-1 -: WORD_W];
    w_selPc   = w_aluHead[WORD_W-1:0];
    case (w_grant)
      SRC_LSB: begin
        w_selTag  = w_lsbHead[RES_W-1 -: TAG_W];
        w_selData = w_lsbHead[WORD_W-1:0];
        w_selPc   = '0;
      end
      SRC_ROB: begin
        w_selTag  = w_robHead[RES_W-1 -: TAG_W];
        w_selData = w_robHead[WORD_W-1:0];
        w_selPc   = '0;
      end
      default: ;
    endcase
  end

  // Idle cycles only drop valid; the payload fields keep their last broadcast.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastGrant <= SRC_ROB;
      r_cdbValid  <= 1'b0;
      r_cdbTag    <= '0;
      r_cdbData   <= '0;
      r_cdbNewPc  <= '0;
      r_cdbSrc    <= SRC_ALU;
    end else if (rollback_in) begin
      r_cdbValid <= 1'b0;
    end else if (w_grantValid) begin
      r_lastGrant <= w_grant;
      r_cdbValid  <= 1'b1;
      r_cdbTag    <= w_selTag;
      r_cdbData   <= w_selData;
      r_cdbNewPc  <= w_selPc;
      r_cdbSrc    <= w_grant;
    end else begin
      r_cdbValid <= 1'b0;
    end
  end

  assign cdb_valid_out  = r_cdbValid;
  assign cdb_tag_out    = r_cdbTag;
  assign cdb_data_out   = r_cdbData;
  assign cdb_new_pc_out = r_cdbNewPc;
  assign cdb_src_out    = r_cdbSrc;

  assert property (@(posedge clk) disable iff (rst) cdb_src_out != 2'd3);
  assert property (@(posedge clk) disable iff (rst)
    !(cdb_valid_out && cdb_src_out != 2'd0 && cdb_new_pc_out != '0));
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed pushes queue expected results per
// source, and a forked monitor compares every valid bus cycle against them.

module tb_cdb_arbiter;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 4;
  localparam int WORD_W = 32;
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_LSB = 2'd1;
  localparam logic [1:0] SRC_ROB = 2'd2;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] data;
    logic [WORD_W-1:0] pc;
  } expItem_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              rollback_in;
  logic              alu_valid_in, lsb_valid_in, rob_valid_in;
  logic [TAG_W-1:0]  alu_tag_in, lsb_tag_in, rob_tag_in;
  logic [WORD_W-1:0] alu_data_in, lsb_data_in, rob_data_in;
  logic [WORD_W-1:0] alu_new_pc_in;
  logic              alu_full_out, lsb_full_out, rob_full_out;
  logic              cdb_valid_out;
  logic [TAG_W-1:0]  cdb_tag_out;
  logic [WORD_W-1:0] cdb_data_out;
  logic [WORD_W-1:0] cdb_new_pc_out;
  logic [1:0]        cdb_src_out;

  expItem_t expAlu[$];
  expItem_t expLsb[$];
  expItem_t expRob[$];
  int checkCount = 0;
  int errorCount = 0;

  cdb_arbiter #(.DEPTH(DEPTH), .TAG_W(TAG_W), .WORD_W(WORD_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .rollback_in    (rollback_in),
    .alu_valid_in   (alu_valid_in),
    .alu_tag_in     (alu_tag_in),
    .alu_data_in    (alu_data_in),
    .alu_new_pc_in  (alu_new_pc_in),
    .alu_full_out   (alu_full_out),
    .lsb_valid_in   (lsb_valid_in),
    .lsb_tag_in     (lsb_tag_in),
    .lsb_data_in    (lsb_data_in),
    .lsb_full_out   (lsb_full_out),
    .rob_valid_in   (rob_valid_in),
    .rob_tag_in     (rob_tag_in),
    .rob_data_in    (rob_data_in),
    .rob_full_out   (rob_full_out),
    .cdb_valid_out  (cdb_valid_out),
    .cdb_tag_out    (cdb_tag_out),
    .cdb_data_out   (cdb_data_out),
    .cdb_new_pc_out (cdb_new_pc_out),
    .cdb_src_out    (cdb_src_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic idleInputs();
    rollback_in   = 1'b0;
    alu_valid_in  = 1'b0; alu_tag_in = '0; alu_data_in = '0; alu_new_pc_in = '0;
    lsb_valid_in  = 1'b0; lsb_tag_in = '0; lsb_data_in = '0;
    rob_valid_in  = 1'b0; rob_tag_in = '0; rob_data_in = '0;
  endtask

  // Drives one producer; expectOnBus records the result the bus must later carry.
  task automatic applyStimulus(input logic [1:0] src, input logic [TAG_W-1:0] tag,
                               input logic [WORD_W-1:0] data, input logic [WORD_W-1:0] pc,
                               input bit expectOnBus);
    expItem_t e;
    e.tag  = tag;
    e.data = data;
    e.pc   = (src == SRC_ALU) ? pc : '0;
    case (src)
      SRC_ALU: begin
        alu_valid_in = 1'b1; alu_tag_in = tag; alu_data_in = data; alu_new_pc_in = pc;
        if (expectOnBus) expAlu.push_back(e);
      end
      SRC_LSB: begin
        lsb_valid_in = 1'b1; lsb_tag_in = tag; lsb_data_in = data;
        if (expectOnBus) expLsb.push_back(e);
      end
      default: begin
        rob_valid_in = 1'b1; rob_tag_in = tag; rob_data_in = data;
        if (expectOnBus) expRob.push_back(e);
      end
    endcase
  endtask

  task automatic compareBus();
    expItem_t e;
    bit have = 1'b0;
    case (cdb_src_out)
      SRC_ALU: if (expAlu.size() > 0) begin e = expAlu.pop_front(); have = 1'b1; end
      SRC_LSB: if (expLsb.size() > 0) begin e = expLsb.pop_front(); have = 1'b1; end
      SRC_ROB: if (expRob.size() > 0) begin e = expRob.pop_front(); have = 1'b1; end
      default: have = 1'b0;
    endcase
    if (!have) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL busUnexpected: got src %0d tag 0x%0h data 0x%0h, expected no result at %0t",
               cdb_src_out, cdb_tag_out, cdb_data_out, $time);
    end else begin
      checkOutput("busTag", 64'(cdb_tag_out), 64'(e.tag));
      checkOutput("busData", 64'(cdb_data_out), 64'(e.data));
      checkOutput("busNewPc", 64'(cdb_new_pc_out), 64'(e.pc));
    end
  endtask

  task automatic runMonitor();
    forever begin
      @(negedge clk);
      if (!rst && cdb_valid_out) compareBus();
    end
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (expAlu.size() + expLsb.size() + expRob.size() == 0) break;
      tick();
    end
    checkOutput(name, 64'(expAlu.size() + expLsb.size() + expRob.size()), 64'(0));
  endtask

  task automatic resetDut();
    idleInputs();
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rstValid", 64'(cdb_valid_out), 64'(0));
    checkOutput("rstTag", 64'(cdb_tag_out), 64'(0));
    checkOutput("rstData", 64'(cdb_data_out), 64'(0));
    checkOutput("rstNewPc", 64'(cdb_new_pc_out), 64'(0));
    checkOutput("rstSrc", 64'(cdb_src_out), 64'(0));
    checkOutput("rstFull", 64'({alu_full_out, lsb_full_out, rob_full_out}), 64'(0));
    rst = 1'b0;
  endtask

  function automatic logic [1:0] loadSrc(input int e);
    if (e == 11) return SRC_LSB;
    if (e == 12) return SRC_ROB;
    if (e < 11) return (e % 2 == 0) ? SRC_ALU : SRC_ROB;
    return (e % 2 == 1) ? SRC_ALU : SRC_ROB;
  endfunction

  initial begin
    rst = 1'b1;
    idleInputs();
    fork
      runMonitor();
    join_none

    // Single ALU result: one cycle latency, then idle.
    resetDut();
    applyStimulus(SRC_ALU, 4'd3, 32'h11, 32'h104, 1'b1);
    tick();
    idleInputs();
    tick();
    checkOutput("t1Valid", 64'(cdb_valid_out), 64'(1));
    checkOutput("t1Src", 64'(cdb_src_out), 64'(SRC_ALU));
    tick();
    checkOutput("t1Idle", 64'(cdb_valid_out), 64'(0));
    waitDrain("t1Drain");

    // Simultaneous pushes rotate ALU, LSB, ROB and the rotation continues.
    resetDut();
    applyStimulus(SRC_ALU, 4'd1, 32'hA1, 32'h200, 1'b1);
    applyStimulus(SRC_LSB, 4'd2, 32'hB2, 32'h0, 1'b1);
    applyStimulus(SRC_ROB, 4'd3, 32'hC3, 32'h0, 1'b1);
    tick();
    idleInputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("t2SrcFirst", 64'(cdb_src_out), 64'(k));
    end
    applyStimulus(SRC_ALU, 4'd4, 32'hA4, 32'h204, 1'b1);
    applyStimulus(SRC_LSB, 4'd5, 32'hB5, 32'h0, 1'b1);
    applyStimulus(SRC_ROB, 4'd6, 32'hC6, 32'h0, 1'b1);
    tick();
    idleInputs();
    checkOutput("t2Gap", 64'(cdb_valid_out), 64'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("t2SrcSecond", 64'(cdb_src_out), 64'(k));
    end
    waitDrain("t2Drain");

    // LSB fills while sharing the bus with ALU; a push into the full FIFO is dropped.
    resetDut();
    for (int c = 1; c <= 6; c++) begin
      idleInputs();
      applyStimulus(SRC_ALU, 4'(c), 32'h100 + c, 32'h1000 + c, 1'b1);
      applyStimulus(SRC_LSB, 4'(6 + c), 32'h200 + c, 32'h0, 1'b1);
      tick();
    end
    idleInputs();
    checkOutput("t3LsbFull", 64'(lsb_full_out), 64'(1));
    checkOutput("t3AluNotFull", 64'(alu_full_out), 64'(0));
    applyStimulus(SRC_LSB, 4'd13, 32'h207, 32'h0, 1'b0);
    tick();
    idleInputs();
    checkOutput("t3LsbAfterDrop", 64'(lsb_full_out), 64'(0));
    waitDrain("t3Drain");

    // Null tag never reaches the bus nor occupies a slot.
    applyStimulus(SRC_ALU, 4'd0, 32'hDEAD, 32'hBEEF, 1'b0);
    tick();
    idleInputs();
    tick();
    checkOutput("t4NullIdle1", 64'(cdb_valid_out), 64'(0));
    tick();
    checkOutput("t4NullIdle2", 64'(cdb_valid_out), 64'(0));
    applyStimulus(SRC_ALU, 4'd5, 32'h55, 32'h500, 1'b1);
    tick();
    idleInputs();
    tick();
    checkOutput("t4RealValid", 64'(cdb_valid_out), 64'(1));
    waitDrain("t4Drain");

    // Rollback flushes queued results and the concurrent push; last grant survives.
    resetDut();
    applyStimulus(SRC_ALU, 4'd1, 32'h301, 32'h3001, 1'b1);
    applyStimulus(SRC_LSB, 4'd2, 32'h302, 32'h0, 1'b1);
    applyStimulus(SRC_ROB, 4'd3, 32'h303, 32'h0, 1'b1);
    tick();
    idleInputs();
    applyStimulus(SRC_ALU, 4'd4, 32'h304, 32'h3004, 1'b1);
    applyStimulus(SRC_LSB, 4'd5, 32'h305, 32'h0, 1'b1);
    applyStimulus(SRC_ROB, 4'd6, 32'h306, 32'h0, 1'b1);
    tick();
    idleInputs();
    rollback_in = 1'b1;
    applyStimulus(SRC_ALU, 4'd7, 32'h307, 32'h3007, 1'b0);
    applyStimulus(SRC_LSB, 4'd8, 32'h308, 32'h0, 1'b0);
    applyStimulus(SRC_ROB, 4'd9, 32'h309, 32'h0, 1'b0);
    tick();
    idleInputs();
    expAlu.delete();
    expLsb.delete();
    expRob.delete();
    checkOutput("t5RollbackValid", 64'(cdb_valid_out), 64'(0));
    checkOutput("t5RollbackFull", 64'({alu_full_out, lsb_full_out, rob_full_out}), 64'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("t5StaysIdle", 64'(cdb_valid_out), 64'(0));
    end
    applyStimulus(SRC_ALU, 4'd10, 32'h310, 32'h3010, 1'b1);
    applyStimulus(SRC_LSB, 4'd11, 32'h311, 32'h0, 1'b1);
    applyStimulus(SRC_ROB, 4'd12, 32'h312, 32'h0, 1'b1);
    tick();
    idleInputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("t5SrcAfterRollback", 64'(cdb_src_out), 64'((k + 1) % 3));
    end
    waitDrain("t5Drain");

    // Alternating ALU/ROB stream wraps the pointers; LSB cuts in at cycle 10.
    resetDut();
    for (int c = 1; c <= 22; c++) begin
      idleInputs();
      if (c <= 20) begin
        if (c % 2 == 1) applyStimulus(SRC_ALU, 4'((c % 15) + 1), 32'h600 + c, 32'h6000 + c, 1'b1);
        else            applyStimulus(SRC_ROB, 4'((c % 15) + 1), 32'h700 + c, 32'h0, 1'b1);
        if (c == 10)    applyStimulus(SRC_LSB, 4'd9, 32'h610, 32'h0, 1'b1);
      end
      tick();
      if (c >= 2) begin
        checkOutput("t6Valid", 64'(cdb_valid_out), 64'(1));
        checkOutput("t6Src", 64'(cdb_src_out), 64'(loadSrc(c)));
      end
    end
    idleInputs();
    tick();
    checkOutput("t6Idle", 64'(cdb_valid_out), 64'(0));
    waitDrain("t6Drain");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
